// File: rtl/cognitive_state_scheduler.sv
// Schedule sequencer: steps state_select through stored (state, duration) entries on 4 kHz ticks.
// Optional SCHED_LOOP_COUNT_EN adds a saturating loop_count output.
module cognitive_state_scheduler #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned DUR_W         = 16,
  parameter logic [2:0]  DEFAULT_STATE = 3'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_4khz_en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [2:0]               cfg_state,
  input  logic [DUR_W-1:0]         cfg_dur,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     stop,
  output logic [2:0]               state_select,
  output logic [$clog2(DEPTH)-1:0] entry_idx,
  output logic                     busy,
  output logic                     step_pulse,
  output logic                     done_pulse
`ifdef SCHED_LOOP_COUNT_EN
  ,
  output logic [7:0]               loop_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} fsm_t;

  fsm_t             fsm;
  logic [2:0]       mem_state [DEPTH];
  logic [DUR_W-1:0] mem_dur   [DEPTH];
  logic [DEPTH-1:0] mem_vld;
  logic [DUR_W-1:0] cnt;
  logic [NW-1:0]    num_lat;
  logic             loop_lat;

  logic             wr_en;
  logic             num_ok;
  logic             last_entry;
  logic [AW-1:0]    nxt_idx;
  logic [2:0]       st0;
  logic [2:0]       st_nxt;
  logic [DUR_W-1:0] dur0;
  logic [DUR_W-1:0] dur_nxt;

  assign cfg_ready = (fsm == IDLE) || (fsm == DONE);
  assign wr_en     = cfg_valid && cfg_ready;
  assign num_ok    = (num_entries != '0) && (num_entries <= NW'(DEPTH));

  // Schedule storage; payload is unreset, validity tracks which entries were ever written
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_state[cfg_addr] <= cfg_state;
      mem_dur[cfg_addr]   <= cfg_dur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_vld <= '0;
    end else if (wr_en) begin
      mem_vld[cfg_addr] <= 1'b1;
    end
  end

  // Entry read-out: unwritten entries read as state 0, and any zero duration counts as one tick
  always_comb begin
    last_entry = (NW'(entry_idx) + NW'(1)) == num_lat;
    nxt_idx    = last_entry ? '0 : AW'(entry_idx + AW'(1));
    st0        = mem_vld[0] ? mem_state[0] : 3'd0;
    dur0       = (mem_vld[0] && (mem_dur[0] != '0)) ? mem_dur[0] : DUR_W'(1);
    st_nxt     = mem_vld[nxt_idx] ? mem_state[nxt_idx] : 3'd0;
    dur_nxt    = (mem_vld[nxt_idx] && (mem_dur[nxt_idx] != '0)) ? mem_dur[nxt_idx] : DUR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= IDLE;
      state_select <= DEFAULT_STATE;
      entry_idx    <= '0;
      busy         <= 1'b0;
      step_pulse   <= 1'b0;
      done_pulse   <= 1'b0;
      cnt          <= '0;
      num_lat      <= '0;
      loop_lat     <= 1'b0;
`ifdef SCHED_LOOP_COUNT_EN
      loop_count   <= '0;
`endif
    end else begin
      step_pulse <= 1'b0;
      done_pulse <= 1'b0;
      if (stop) begin
        fsm          <= IDLE;
        state_select <= DEFAULT_STATE;
        busy         <= 1'b0;
`ifdef SCHED_LOOP_COUNT_EN
        loop_count   <= '0;
`endif
      end else begin
        case (fsm)
          IDLE, DONE: begin
            if (start && num_ok) begin
              fsm          <= RUN;
              num_lat      <= num_entries;
              loop_lat     <= loop_en;
              cnt          <= dur0;
              entry_idx    <= '0;
              state_select <= st0;
              step_pulse   <= 1'b1;
              busy         <= 1'b1;
`ifdef SCHED_LOOP_COUNT_EN
              loop_count   <= '0;
`endif
            end
          end
          RUN: begin
            // pause takes precedence, so a coincident tick is dropped
            if (pause) begin
              fsm <= PAUSED;
            end else if (clk_4khz_en) begin
              if (cnt > DUR_W'(1)) begin
                cnt <= cnt - DUR_W'(1);
              end else if (last_entry && !loop_lat) begin
                fsm          <= DONE;
                state_select <= DEFAULT_STATE;
                busy         <= 1'b0;
                done_pulse   <= 1'b1;
              end else begin
                cnt          <= dur_nxt;
                entry_idx    <= nxt_idx;
                state_select <= st_nxt;
                step_pulse   <= 1'b1;
`ifdef SCHED_LOOP_COUNT_EN
                if (last_entry && (loop_count != 8'hFF)) begin
                  loop_count <= loop_count + 8'd1;
                end
`endif
              end
            end
          end
          PAUSED: begin
            if (!pause) begin
              fsm <= RUN;
            end
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cognitive_state_scheduler.sv
// Scoreboard bench for cognitive_state_scheduler: a tick-count timeline model predicts step/done events.
module tb_cognitive_state_scheduler;

  localparam int DEPTH = 8;
  localparam int DUR_W = 16;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clk_4khz_en, cfg_valid, cfg_ready;
  logic [AW-1:0]    cfg_addr;
  logic [2:0]       cfg_state;
  logic [DUR_W-1:0] cfg_dur;
  logic [AW:0]      num_entries;
  logic             loop_en, start, pause, stop;
  logic [2:0]       state_select;
  logic [AW-1:0]    entry_idx;
  logic             busy, step_pulse, done_pulse;
`ifdef SCHED_LOOP_COUNT_EN
  logic [7:0]       loop_count;
`endif

  cognitive_state_scheduler #(.DEPTH(DEPTH), .DUR_W(DUR_W), .DEFAULT_STATE(3'd0)) dut (
    .clk(clk), .rst_n(rst_n), .clk_4khz_en(clk_4khz_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_state(cfg_state), .cfg_dur(cfg_dur), .num_entries(num_entries),
    .loop_en(loop_en), .start(start), .pause(pause), .stop(stop),
    .state_select(state_select), .entry_idx(entry_idx), .busy(busy),
    .step_pulse(step_pulse), .done_pulse(done_pulse)
`ifdef SCHED_LOOP_COUNT_EN
    , .loop_count(loop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit done;
    int idx;
    int st;
  } ev_t;
  ev_t q[$];
  ev_t mon_e;

  // Reference model: schedule as a timeline of counted ticks
  int m_active;            // 0 idle/done, 1 running, 2 paused
  int m_st[DEPTH];
  int m_du[DEPTH];
  int s_st[DEPTH];
  int s_du[DEPTH];
  int s_n;
  bit s_loop;
  int m_ticks;
  int m_lc;

  task automatic check(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_active = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_st[i] = 0;
      m_du[i] = 0;
    end
    m_lc = 0;
    q.delete();
  endtask

  task automatic push_ev(input bit d, input int idx, input int st);
    ev_t e;
    e.cyc = cyc + 1;
    e.done = d;
    e.idx = idx;
    e.st = st;
    q.push_back(e);
  endtask

  task automatic model_tick();
    int total, acc, pos;
    total = 0;
    acc = 0;
    for (int k = 0; k < s_n; k++) total += eff(s_du[k]);
    m_ticks++;
    if (!s_loop && m_ticks == total) begin
      push_ev(1'b1, s_n - 1, 0);
      m_active = 0;
    end else begin
      pos = m_ticks % total;
      for (int k = 0; k < s_n; k++) begin
        if (pos == acc) begin
          push_ev(1'b0, k, s_st[k]);
          if (k == 0 && m_lc < 255) m_lc++;
        end
        acc += eff(s_du[k]);
      end
    end
  endtask

  // Evaluate the inputs about to be sampled on the next rising edge
  task automatic model_step();
    int was;
    was = m_active;
    if (cfg_valid) check("cfg_ready", int'(cfg_ready), int'(was == 0));
    if (stop) begin
      m_active = 0;
      m_lc = 0;
    end else if (was == 0) begin
      if (start && num_entries >= 1 && num_entries <= DEPTH) begin
        for (int i = 0; i < DEPTH; i++) begin
          s_st[i] = m_st[i];
          s_du[i] = m_du[i];
        end
        s_n = int'(num_entries);
        s_loop = loop_en;
        m_ticks = 0;
        m_active = 1;
        m_lc = 0;
        push_ev(1'b0, 0, s_st[0]);
      end
    end else if (was == 1) begin
      if (pause) m_active = 2;
      else if (clk_4khz_en) model_tick();
    end else if (!pause) begin
      m_active = 1;
    end
    if (cfg_valid && was == 0) begin
      m_st[cfg_addr] = int'(cfg_state);
      m_du[cfg_addr] = int'(cfg_dur);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents an event
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_event: got none, required done=%0b idx %0d at cycle %0d", q[0].done, q[0].idx, q[0].cyc);
        void'(q.pop_front());
      end
      if (step_pulse || done_pulse) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got step %0b done %0b idx %0d at cycle %0d, required none", step_pulse, done_pulse, entry_idx, cyc);
        end else begin
          mon_e = q.pop_front();
          check("ev_cycle", cyc, mon_e.cyc);
          check("ev_done", int'(done_pulse), int'(mon_e.done));
          check("ev_step", int'(step_pulse), int'(!mon_e.done));
          check("ev_idx", int'(entry_idx), mon_e.idx);
          check("ev_state", int'(state_select), mon_e.st);
        end
      end
    end
  end

  task automatic clk1();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int s, input int d);
    cfg_valid = 1'b1;
    cfg_addr = AW'(a);
    cfg_state = 3'(s);
    cfg_dur = DUR_W'(d);
    clk1();
    cfg_valid = 1'b0;
  endtask

  task automatic go(input int n, input bit lp);
    start = 1'b1;
    num_entries = (AW + 1)'(n);
    loop_en = lp;
    clk1();
    start = 1'b0;
  endtask

  task automatic tk(input int n, input int gap);
    repeat (n) begin
      clk_4khz_en = 1'b1;
      clk1();
      clk_4khz_en = 1'b0;
      repeat (gap) clk1();
    end
  endtask

  task automatic chk_lc();
`ifdef SCHED_LOOP_COUNT_EN
    check("loop_count", int'(loop_count), m_lc);
`endif
  endtask

  task automatic run_to_idle(input int budget);
    int b;
    b = 0;
    while (m_active != 0 && b < budget) begin
      tk(1, 1);
      b++;
    end
    if (m_active != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_timeout: got still running after %0d ticks, required idle", budget);
    end
    clk1();
    check("idle_busy", int'(busy), 0);
    check("idle_state", int'(state_select), 0);
    check("idle_cfg_ready", int'(cfg_ready), 1);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    clk1();
    stop = 1'b0;
    clk1();
    check("stop_busy", int'(busy), 0);
    check("stop_state", int'(state_select), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    {clk_4khz_en, cfg_valid, loop_en, start, pause, stop} = '0;
    cfg_addr = '0;
    cfg_state = '0;
    cfg_dur = '0;
    num_entries = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", int'(state_select), 0);
    check("rst_idx", int'(entry_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step", int'(step_pulse), 0);
    check("rst_done", int'(done_pulse), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clk1();

    // Basic two-entry schedule
    wr(0, 4, 3);
    wr(1, 0, 5);
    go(2, 1'b0);
    run_to_idle(40);

    // Looping three-entry schedule, 13 ticks
    wr(0, 1, 2);
    wr(1, 2, 2);
    wr(2, 3, 2);
    go(3, 1'b1);
    tk(13, 1);
    check("loop_busy", int'(busy), 1);
    chk_lc();
    do_stop();
    chk_lc();

    // Pause for 50 clocks after 4 ticks, with a tick coincident on pause entry
    wr(0, 5, 10);
    wr(1, 6, 2);
    go(2, 1'b0);
    tk(4, 1);
    pause = 1'b1;
    clk_4khz_en = 1'b1;
    clk1();
    for (int i = 0; i < 49; i++) begin
      clk_4khz_en = (i % 5 == 0);
      clk1();
    end
    pause = 1'b0;
    clk_4khz_en = 1'b0;
    clk1();
    run_to_idle(40);

    // start and stop together stay idle
    start = 1'b1;
    stop = 1'b1;
    num_entries = 4'd2;
    clk1();
    start = 1'b0;
    stop = 1'b0;
    clk1();
    check("race_busy", int'(busy), 0);

    // Zero duration holds one tick
    wr(0, 7, 0);
    wr(1, 3, 1);
    go(2, 1'b0);
    run_to_idle(20);

    // Out-of-range entry counts are ignored
    go(0, 1'b0);
    clk1();
    check("n0_busy", int'(busy), 0);
    go(DEPTH + 1, 1'b0);
    clk1();
    check("n9_busy", int'(busy), 0);

    // Config write held while busy, accepted once done
    wr(0, 2, 4);
    go(1, 1'b0);
    cfg_valid = 1'b1;
    cfg_addr = '0;
    cfg_state = 3'd5;
    cfg_dur = 16'd2;
    for (int b = 0; b < 20 && m_active != 0; b++) tk(1, 0);
    clk1();
    cfg_valid = 1'b0;
    clk1();
    go(1, 1'b0);
    run_to_idle(20);

    // Asynchronous reset mid-entry
    wr(0, 3, 20);
    go(1, 1'b0);
    tk(3, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_state", int'(state_select), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_idx", int'(entry_idx), 0);
    check("arst_cfg_ready", int'(cfg_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clk1();
    go(1, 1'b0);
    run_to_idle(10);

    // Randomised sessions
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) wr(a, int'($urandom % 8), int'($urandom_range(0, 4)));
      go(int'($urandom_range(1, DEPTH)), 1'($urandom % 2));
      for (int c = 0; c < 150; c++) begin
        clk_4khz_en = ($urandom % 3 == 0);
        if ($urandom % 12 == 0) pause = ~pause;
        stop = ($urandom % 100 == 0);
        start = ($urandom % 25 == 0);
        num_entries = (AW + 1)'($urandom_range(0, DEPTH + 1));
        loop_en = 1'($urandom % 2);
        clk1();
      end
      {clk_4khz_en, pause, stop, start} = '0;
      clk1();
      chk_lc();
      do_stop();
    end

    clk1();
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
